// File: rtl/imem_program_loader.sv
// Boot loader: framed little-endian byte stream -> instruction memory word writes.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module imem_program_loader #(
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int IDXW = $clog2(IMEM_WORDS) + 1;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR = 3'd0, S_DATA = 3'd1, S_WRITE = 3'd2, S_DONE = 3'd3, S_ERR = 3'd4, S_CSUM = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HDR = 3'd0, S_DATA = 3'd1, S_WRITE = 3'd2, S_DONE = 3'd3, S_ERR = 3'd4
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [IDXW-1:0]   n_q, n_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic              imem_we_q, imem_we_d;
  logic [31:0]       imem_addr_q, imem_addr_d;
  logic [31:0]       imem_data_q, imem_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              rx_ready_s;
  logic              accept_s;
  logic [31:0]       word_s;
  logic [IDXW-1:0]   idx_inc_s;

  // Byte acceptance is a pure decode of the current state.
  always_comb begin
    case (state_q)
      S_HDR, S_DATA: rx_ready_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:        rx_ready_s = 1'b1;
`endif
      default:       rx_ready_s = 1'b0;
    endcase
  end

  assign accept_s  = rx_valid && rx_ready_s;
  // First byte of a word ends up in [7:0] after four shifts.
  assign word_s    = {rx_data, asm_q[31:8]};
  assign idx_inc_s = idx_q + {{(IDXW-1){1'b0}}, 1'b1};

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    n_d         = n_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    error_d     = error_q;
    case (state_q)
      S_HDR: begin
        if (accept_s) begin
          asm_d      = word_s;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (word_s == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d    = S_DONE;
              cpu_hold_d = 1'b0;
              done_d     = 1'b1;
`endif
            end else if (word_s > 32'(IMEM_WORDS)) begin
              state_d = S_ERR;
              error_d = 1'b1;
            end else begin
              n_d     = word_s[IDXW-1:0];
              idx_d   = {IDXW{1'b0}};
              asm_d   = 32'd0;
              state_d = S_DATA;
            end
          end else begin
            state_d = S_HDR;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          asm_d      = word_s;
          byte_cnt_d = byte_cnt_q + 2'd1;
          csum_d     = csum_q ^ rx_data;
          if (byte_cnt_q == 2'd3) begin
            state_d     = S_WRITE;
            imem_we_d   = 1'b1;
            imem_data_d = word_s;
            imem_addr_d = BASE_ADDR + (32'(idx_q) << 32'd2);
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_WRITE: begin
        idx_d = idx_inc_s;
        if (idx_inc_s == n_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d    = S_DONE;
          cpu_hold_d = 1'b0;
          done_d     = 1'b1;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept_s) begin
          if (rx_data == csum_q) begin
            state_d    = S_DONE;
            cpu_hold_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end else begin
          state_d = S_CSUM;
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR;
          done_d     = 1'b0;
          error_d    = 1'b0;
          cpu_hold_d = 1'b1;
          byte_cnt_d = 2'd0;
          asm_d      = 32'd0;
          idx_d      = {IDXW{1'b0}};
          n_d        = {IDXW{1'b0}};
          csum_d     = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HDR;
      byte_cnt_q  <= 2'd0;
      asm_q       <= 32'd0;
      n_q         <= {IDXW{1'b0}};
      idx_q       <= {IDXW{1'b0}};
      csum_q      <= 8'd0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= BASE_ADDR;
      imem_data_q <= 32'd0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rx_ready  = rx_ready_s;
  assign imem_we   = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_data = imem_data_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed self-checking bench for imem_program_loader (default and LOADER_CHECKSUM_EN builds).
module tb_imem_program_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  imem_program_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Log every write pulse seen mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_data);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: rx_ready stayed 0 for byte %02h", b);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b exp 0", imem_we); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %08h exp 0", imem_addr); end
    checks++; if (imem_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %08h exp 0", imem_data); end
    checks++; if ({done, error, cpu_hold, rx_ready} !== 4'b0011)
      begin errors++; $display("FAIL rst_status: got %04b exp 0011", {done, error, cpu_hold, rx_ready}); end
    rst = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic test_single_word();
    do_reset();
    send_word(32'h0000_0001, 0);
    send_word(32'h0010_0513, 0);
    @(negedge clk);
    checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL single_latency_we: got %0b exp 1", imem_we); end
    checks++; if (imem_data !== 32'h0010_0513) begin errors++; $display("FAIL single_latency_data: got %08h exp 00100513", imem_data); end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h06, 0);
`endif
    repeat (3) @(negedge clk);
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL single_we_count: got %0d exp 1", wa.size()); end
    if (wa.size() == 1) begin
      checks++; if (wa[0] !== 32'h0) begin errors++; $display("FAIL single_addr: got %08h exp 0", wa[0]); end
      checks++; if (wd[0] !== 32'h0010_0513) begin errors++; $display("FAIL single_data: got %08h exp 00100513", wd[0]); end
    end
    checks++; if ({done, error, cpu_hold, rx_ready} !== 4'b1000)
      begin errors++; $display("FAIL single_status: got %04b exp 1000", {done, error, cpu_hold, rx_ready}); end
  endtask

  task automatic test_gapped();
    logic [31:0] exp_d[3];
    exp_d[0] = 32'h1111_1111;
    exp_d[1] = 32'h2222_2222;
    exp_d[2] = 32'h3333_3333;
    do_reset();
    send_word(32'h0000_0003, 1);
    for (int i = 0; i < 3; i++) send_word(exp_d[i], 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 1);
`endif
    repeat (3) @(negedge clk);
    checks++; if (wa.size() !== 3) begin errors++; $display("FAIL gap_we_count: got %0d exp 3", wa.size()); end
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      checks++; if (wa[i] !== 32'(4 * i)) begin errors++; $display("FAIL gap_addr%0d: got %08h exp %08h", i, wa[i], 4 * i); end
      checks++; if (wd[i] !== exp_d[i]) begin errors++; $display("FAIL gap_data%0d: got %08h exp %08h", i, wd[i], exp_d[i]); end
    end
    checks++; if ({done, error, cpu_hold} !== 3'b100) begin errors++; $display("FAIL gap_status: got %03b exp 100", {done, error, cpu_hold}); end
  endtask

  task automatic test_oversize();
    do_reset();
    send_word(32'h0000_0401, 0);
    repeat (3) @(negedge clk);
    checks++; if ({done, error, cpu_hold, rx_ready} !== 4'b0110)
      begin errors++; $display("FAIL over_status: got %04b exp 0110", {done, error, cpu_hold, rx_ready}); end
    checks++; if (wa.size() !== 0) begin errors++; $display("FAIL over_we_count: got %0d exp 0", wa.size()); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({done, error, cpu_hold, rx_ready} !== 4'b0011)
      begin errors++; $display("FAIL over_restart: got %04b exp 0011", {done, error, cpu_hold, rx_ready}); end
  endtask

  task automatic test_max_header();
    do_reset();
    send_word(32'h0000_0400, 0);
    repeat (2) @(negedge clk);
    checks++; if ({done, error, cpu_hold, rx_ready} !== 4'b0011)
      begin errors++; $display("FAIL max_hdr_status: got %04b exp 0011", {done, error, cpu_hold, rx_ready}); end
  endtask

  task automatic test_zero();
    do_reset();
    send_word(32'h0000_0000, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    repeat (2) @(negedge clk);
    checks++; if ({done, error, cpu_hold, rx_ready} !== 4'b1000)
      begin errors++; $display("FAIL zero_status: got %04b exp 1000", {done, error, cpu_hold, rx_ready}); end
    checks++; if (wa.size() !== 0) begin errors++; $display("FAIL zero_we_count: got %0d exp 0", wa.size()); end
`ifdef LOADER_CHECKSUM_EN
    do_reset();
    send_word(32'h0000_0000, 0);
    send_byte(8'h5A, 0);
    repeat (2) @(negedge clk);
    checks++; if ({done, error, cpu_hold} !== 3'b011) begin errors++; $display("FAIL zero_bad_csum: got %03b exp 011", {done, error, cpu_hold}); end
`endif
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_word(32'h0000_0002, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({imem_we, done, error, cpu_hold, rx_ready} !== 5'b00011)
      begin errors++; $display("FAIL midrst_status: got %05b exp 00011", {imem_we, done, error, cpu_hold, rx_ready}); end
    checks++; if (imem_addr !== 32'h0 || imem_data !== 32'h0)
      begin errors++; $display("FAIL midrst_regs: got %08h/%08h exp 0/0", imem_addr, imem_data); end
    @(negedge clk);
    rst = 1'b0;
    wa.delete();
    wd.delete();
    send_word(32'h0000_0001, 0);
    send_word(32'hDEAD_BEEF, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h22, 0);
`endif
    repeat (3) @(negedge clk);
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL midrst_we_count: got %0d exp 1", wa.size()); end
    if (wa.size() == 1) begin
      checks++; if (wa[0] !== 32'h0 || wd[0] !== 32'hDEAD_BEEF)
        begin errors++; $display("FAIL midrst_write: got %08h/%08h exp 0/deadbeef", wa[0], wd[0]); end
    end
    checks++; if ({done, error, cpu_hold} !== 3'b100) begin errors++; $display("FAIL midrst_done: got %03b exp 100", {done, error, cpu_hold}); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    send_word(32'h0000_0001, 0);
    send_word(32'h0804_0201, 0);
    send_byte(8'h0F, 0);
    repeat (2) @(negedge clk);
    checks++; if ({done, error, cpu_hold} !== 3'b100) begin errors++; $display("FAIL csum_good: got %03b exp 100", {done, error, cpu_hold}); end
    do_reset();
    send_word(32'h0000_0001, 0);
    send_word(32'h0804_0201, 0);
    send_byte(8'h0E, 0);
    repeat (2) @(negedge clk);
    checks++; if ({done, error, cpu_hold} !== 3'b011) begin errors++; $display("FAIL csum_bad: got %03b exp 011", {done, error, cpu_hold}); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_gapped();
    test_oversize();
    test_max_header();
    test_zero();
    test_mid_reset();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Byte-stream boot loader that sits directly upstream of the instruction memory's write port.
- Accepts a framed program image over a valid/ready byte interface, assembles little-endian 32-bit words, and issues single-cycle word writes (we/addr/data).
- Holds the core in reset until loading completes.
- Re-armable via a start pulse for reloads without a global reset.

Parameters:
IMEM_WORDS, 1024, instruction memory depth in words; header word counts above this are rejected.
BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-byte aligned.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; re-arms the loader from DONE or ERR
rx_data  input  8  incoming image byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction memory write enable, one-cycle pulse per word
imem_addr  output  32  byte address of word being written
imem_data  output  32  assembled instruction word
cpu_hold  output  1  holds the core in reset while high
done  output  1  image loaded successfully (level)
error  output  1  image rejected (level)

Behaviour:
- Reset: clk is the single clock; rst is asynchronous, active-high. Reset state is HDR.
- Registered output reset values: imem_we=0, imem_addr=BASE_ADDR, imem_data=0, cpu_hold=1, done=0, error=0.
- rx_ready is a decode of state: 1 in HDR/DATA (and CSUM), 0 elsewhere. It is therefore 1 immediately out of reset.
- A byte transfers only when rx_valid && rx_ready on a rising edge. rx_data is ignored otherwise.
- Framing: 4-byte little-endian word count N, then N words, each 4 bytes little-endian (first byte -> bits [7:0]).
- States:
  - HDR: collect 4 count bytes (2-bit byte counter).
    - On 4th byte: N==0 -> DONE; N>IMEM_WORDS -> ERR; else store N, clear word index, go DATA.
  - DATA: shift bytes into the word assembly register. On 4th byte of a word, go WRITE.
  - WRITE (1 cycle): imem_we=1, imem_data=assembled word, imem_addr=BASE_ADDR+4*index; rx_ready=0.
    - Next: increment index. If index+1==N, go DONE (or CSUM when the option is enabled); else go DATA.
  - DONE: cpu_hold=0, done=1, rx_ready=0. Stays here until start or rst.
  - ERR: cpu_hold=1, error=1, rx_ready=0. Stays here until start or rst.
- start:
  - In DONE/ERR, start -> HDR: clear done/error, set cpu_hold=1, clear counters and assembly register.
  - start in HDR/DATA/WRITE is ignored.
- Latency: the write pulse occurs exactly one cycle after the 4th byte of a word is accepted. Max throughput is 4 bytes per 5 cycles.
- Word index width is clog2(IMEM_WORDS)+1. Address arithmetic is 32-bit and never wraps, since N is capped at IMEM_WORDS.
- A back-to-back valid stream with gaps (rx_valid low) must assemble identically to a gapless stream.
- rst asserted mid-load: immediately return to HDR with all reset values. Any partial image is abandoned; memory contents are left as written.
- imem_we is never high outside WRITE.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, the loader enters CSUM with rx_ready=1 and accepts one byte.
  - That byte must equal the XOR of all 4*N data bytes (count bytes excluded). Match -> DONE; mismatch -> ERR.
  - For N==0, the header is followed by a checksum byte that must be 8'h00.
- Undefined: no CSUM state exists; the last WRITE goes directly to DONE, and N==0 goes directly to DONE.

Test Plan:
- Reset, stream 01 00 00 00, 13 05 10 00 -> one imem_we pulse, addr=0x0, data=0x00100513; then done=1, cpu_hold=0, rx_ready=0.
- N=3 words 0x11111111/0x22222222/0x33333333 with rx_valid toggling every other cycle -> writes at 0x0/0x4/0x8 with the correct data, exactly 3 we pulses.
- Header N=1025 (01 04 00 00) -> error=1, cpu_hold=1, no imem_we, rx_ready=0; then start pulse -> HDR, error=0, rx_ready=1.
- Header N=0 -> done=1 with no writes (without the macro). With the macro, checksum byte 00 -> done; byte 5A -> error.
- rst pulsed after 6 bytes of an N=2 image -> outputs at reset values; a fresh full N=1 image then loads correctly at addr 0x0.
- With LOADER_CHECKSUM_EN, N=1 word bytes 01 02 04 08, checksum 0F -> done=1; same word with checksum 0E -> error=1.
